// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between an upstream show-ahead FIFO, the word packer and the
// downstream beat consumer.
interface fifo_word_packer_if #(
  parameter int unsigned width = 8,
  parameter int unsigned ratio = 4
);
  logic                         fifo_empty;
  logic [width-1:0]             fifo_read_data;
  logic                         fifo_pop;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [width*ratio-1:0]       out_data;
  logic [$clog2(ratio+1)-1:0]   out_count;

  modport master (
    input  fifo_empty, fifo_read_data, flush, out_ready,
    output fifo_pop, out_valid, out_data, out_count
  );

  modport slave (
    output fifo_empty, fifo_read_data, flush, out_ready,
    input  fifo_pop, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs ratio consecutive FIFO words into one wide beat; flush emits a partial
// beat with the unused upper slots zeroed.
module fifo_word_packer #(
  parameter int unsigned width = 8,
  parameter int unsigned ratio = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_word_packer_if.master  bus
);
  localparam int unsigned CW = $clog2(ratio);
  localparam int unsigned NW = $clog2(ratio + 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [width*ratio-1:0] data_q, data_d;
  logic [NW-1:0]          count_q, count_d;
  logic                   pop;

  // Popping in HOLD is only allowed alongside a transfer, giving zero-bubble flow.
  assign pop = !bus.fifo_empty && !rst && (state_q == COLLECT || bus.out_ready);

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = data_q;
  assign bus.out_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      COLLECT: begin
        if (pop) begin
          for (int unsigned k = 0; k < ratio; k++) begin
            if (k == 32'(cnt_q)) data_d[k*width +: width] = bus.fifo_read_data;
          end
          if (32'(cnt_q) == ratio - 1) begin
            state_d = HOLD;
            count_d = NW'(ratio);
            cnt_d   = '0;
          end else if (bus.flush) begin
            state_d = HOLD;
            count_d = NW'(cnt_q) + NW'(1);
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else if (bus.flush && cnt_q != '0) begin
          state_d = HOLD;
          count_d = NW'(cnt_q);
          cnt_d   = '0;
        end
      end
      HOLD: begin
        // Flush is deliberately not latched here; only a transfer leaves HOLD.
        if (bus.out_ready) begin
          state_d = COLLECT;
          data_d  = '0;
          count_d = '0;
          cnt_d   = '0;
          if (pop) begin
            data_d[width-1:0] = bus.fifo_read_data;
            cnt_d             = CW'(1);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed self-checking bench for fifo_word_packer with width=8, ratio=4.
module tb_fifo_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.width(8), .ratio(4)) bus ();

  fifo_word_packer #(.width(8), .ratio(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one word, confirm it is popped, and clock it in.
  task automatic push(input logic [7:0] w);
    bus.fifo_empty     = 1'b0;
    bus.fifo_read_data = w;
    #1 chk("pop_on_push", 32'(bus.fifo_pop), 32'd1);
    cyc();
  endtask

  logic [31:0] beats [3];

  initial begin
    beats[0] = 32'h04030201;
    beats[1] = 32'h08070605;
    beats[2] = 32'h0C0B0A09;
    bus.fifo_empty     = 1'b0;
    bus.fifo_read_data = 8'h5A;
    bus.flush          = 1'b0;
    bus.out_ready      = 1'b0;

    // Reset state, with a non-empty FIFO that must not be popped
    cyc();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    chk("rst_data",  bus.out_data,       32'd0);
    chk("rst_pop",   32'(bus.fifo_pop),  32'd0);
    bus.fifo_empty = 1'b1;
    rst = 1'b0;
    cyc();

    // Basic full beat
    push(8'h11); push(8'h22); push(8'h33);
    chk("b1_not_yet", 32'(bus.out_valid), 32'd0);
    push(8'h44);
    bus.fifo_empty = 1'b1;
    bus.out_ready  = 1'b1;
    chk("b1_valid", 32'(bus.out_valid), 32'd1);
    chk("b1_data",  bus.out_data,       32'h44332211);
    chk("b1_count", 32'(bus.out_count), 32'd4);
    #1 chk("b1_no_pop_empty", 32'(bus.fifo_pop), 32'd0);
    cyc();
    chk("b1_done", 32'(bus.out_valid), 32'd0);

    // Continuous stream of 12 words, no bubbles
    for (int i = 0; i < 12; i++) begin
      push(8'(i + 1));
      if (i % 4 == 3) begin
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_data",  bus.out_data,       beats[i/4]);
        chk("stream_count", 32'(bus.out_count), 32'd4);
      end else begin
        chk("stream_collect", 32'(bus.out_valid), 32'd0);
      end
    end

    // Backpressure: hold beat 3 stable, then zero-bubble restart into slot 0
    bus.out_ready      = 1'b0;
    bus.fifo_empty     = 1'b0;
    bus.fifo_read_data = 8'h55;
    #1 chk("bp_no_pop", 32'(bus.fifo_pop), 32'd0);
    cyc();
    chk("bp_stable_data",  bus.out_data,       32'h0C0B0A09);
    chk("bp_stable_valid", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("bp_stable_data2",  bus.out_data,       32'h0C0B0A09);
    chk("bp_stable_count2", 32'(bus.out_count), 32'd4);
    bus.out_ready = 1'b1;
    push(8'h55);
    chk("bp_released", 32'(bus.out_valid), 32'd0);
    push(8'h66); push(8'h77); push(8'h88);
    chk("bp_next_data",  bus.out_data,       32'h88776655);
    chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
    bus.fifo_empty = 1'b1;
    cyc();
    chk("bp_next_done", 32'(bus.out_valid), 32'd0);

    // Flush with no pop in the flush cycle; flush in HOLD not queued
    bus.out_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    bus.fifo_empty = 1'b1;
    bus.flush      = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fl2_valid", 32'(bus.out_valid), 32'd1);
    chk("fl2_data",  bus.out_data,       32'h0000BBAA);
    chk("fl2_count", 32'(bus.out_count), 32'd2);
    bus.flush = 1'b1;
    cyc();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("fl2_done", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("fl_hold_not_queued", 32'(bus.out_valid), 32'd0);

    // Flush with empty collector is ignored
    bus.flush = 1'b1;
    cyc();
    bus.flush = 1'b0;
    chk("fl0_ignored", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("fl0_ignored2", 32'(bus.out_valid), 32'd0);

    // Flush coincident with a pop includes the popped word
    bus.out_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    bus.flush = 1'b1;
    push(8'hCC);
    bus.flush      = 1'b0;
    bus.fifo_empty = 1'b1;
    chk("fl3_valid", 32'(bus.out_valid), 32'd1);
    chk("fl3_data",  bus.out_data,       32'h00CCBBAA);
    chk("fl3_count", 32'(bus.out_count), 32'd3);
    bus.out_ready = 1'b1;
    cyc();
    chk("fl3_done", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-collection
    push(8'h11); push(8'h22);
    bus.fifo_empty = 1'b0;
    bus.fifo_read_data = 8'h33;
    #2 rst = 1'b1;
    #1 chk("rstc_pop",   32'(bus.fifo_pop),  32'd0);
    chk("rstc_valid", 32'(bus.out_valid), 32'd0);
    cyc();
    rst = 1'b0;
    bus.fifo_empty = 1'b1;
    cyc();

    // Asynchronous reset while holding a beat
    bus.out_ready = 1'b0;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("rsth_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.fifo_empty = 1'b0;
    bus.fifo_read_data = 8'h77;
    #2 rst = 1'b1;
    #1 chk("rsth_valid", 32'(bus.out_valid), 32'd0);
    chk("rsth_count", 32'(bus.out_count), 32'd0);
    chk("rsth_data",  bus.out_data,       32'd0);
    chk("rsth_pop",   32'(bus.fifo_pop),  32'd0);
    cyc();
    chk("rsth_pop_held", 32'(bus.fifo_pop), 32'd0);
    rst = 1'b0;

    // First beat after reset starts at slot 0
    push(8'h99); push(8'hA1); push(8'hB2); push(8'hC3);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_data",  bus.out_data,       32'hC3B2A199);
    chk("post_rst_count", 32'(bus.out_count), 32'd4);
    bus.fifo_empty = 1'b1;
    bus.out_ready  = 1'b1;
    cyc();
    chk("post_rst_done", 32'(bus.out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_word_packer.md
FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

Interface
REQ-001 Parameter: width, 8, bit width of one FIFO word.
REQ-002 Parameter: ratio, 4, FIFO words per output beat; legal range 2..16.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 fifo_empty  input  1  empty flag of upstream show-ahead FIFO.
REQ-006 fifo_read_data  input  width  head word of upstream FIFO; valid whenever fifo_empty=0.
REQ-007 fifo_pop  output  1  consumes the head word in the same cycle it is asserted.
REQ-008 flush  input  1  single-cycle request to emit a partially filled beat.
REQ-009 out_valid  output  1  out_data/out_count hold a beat.
REQ-010 out_ready  input  1  downstream accepts the beat when out_valid and out_ready are both 1.
REQ-011 out_data  output  width*ratio  packed beat; word k in bits [k*width +: width].
REQ-012 out_count  output  $clog2(ratio+1)  number of valid words in the beat, 1..ratio.

Function
REQ-013 The block SHALL have two states: COLLECT (out_valid=0) and HOLD (out_valid=1).
REQ-014 fifo_pop SHALL equal !fifo_empty & !rst & (state==COLLECT | out_ready); combinational, never asserted when fifo_empty=1.
REQ-015 A pop in COLLECT SHALL store fifo_read_data into slot cnt and increment cnt (width $clog2(ratio)).
REQ-016 A pop in COLLECT with cnt==ratio-1 SHALL move to HOLD with out_count=ratio and cnt=0.
REQ-017 flush in COLLECT with cnt>0 or a pop that cycle SHALL move to HOLD with out_count = cnt + pop; a word popped in the flush cycle is included.
REQ-018 flush in COLLECT with cnt==0 and no pop SHALL be ignored; flush in HOLD SHALL be ignored (not queued).
REQ-019 Unfilled slots of a partial beat SHALL read as zero.
REQ-020 out_data, out_count, out_valid SHALL be registered and stable while out_valid=1 and out_ready=0.
REQ-021 A transfer (HOLD, out_ready=1) SHALL clear all slots; if fifo_pop is also 1, the popped word SHALL land in slot 0 and cnt SHALL become 1, giving zero-bubble throughput of one word per cycle.
REQ-022 After a transfer the state SHALL be COLLECT, except when ratio words are already complete (never possible in one cycle since ratio>=2).
REQ-023 Latency: beat presented out_valid=1 in the cycle after the popping/flush edge that completed it.
REQ-024 out_ready while out_valid=0 SHALL have no effect.
REQ-025 Word order SHALL be preserved: first popped word in slot 0.

Reset
REQ-026 rst=1 SHALL immediately force state=COLLECT, cnt=0, all slots=0, out_valid=0, out_count=0, out_data=0, fifo_pop=0.
REQ-027 Reset mid-beat SHALL discard partial or held data; no word SHALL be popped in any cycle with rst=1.
REQ-028 After rst deasserts, popping SHALL resume on the first edge with fifo_empty=0.

Verification
REQ-029 ratio=4, width=8, push 0x11,0x22,0x33,0x44, out_ready=1 -> one beat out_data=0x44332211, out_count=4, 4 pops in 4 cycles.
REQ-030 Stream 12 words continuously, out_ready=1 -> 3 beats, fifo_pop high every cycle, no bubbles, order preserved.
REQ-031 out_ready=0 after a full beat with FIFO non-empty -> fifo_pop=0, out_data stable until out_ready=1, then next word popped in that same cycle into slot 0.
REQ-032 Push 0xAA,0xBB then flush (no pop that cycle) -> out_data=0x0000BBAA, out_count=2; flush with cnt=0, fifo_empty=1 -> no beat.
REQ-033 Flush coincident with pop of third word 0xCC after 0xAA,0xBB -> out_data=0x00CCBBAA, out_count=3.
REQ-034 Assert rst asynchronously with cnt=2 and during HOLD -> out_valid=0, out_count=0, fifo_pop=0 immediately; next beat after release starts at slot 0.
